// File: rtl/led_pkg.sv
// Shared types and default sizing for the RGB LED fader.
package led_pkg;

  typedef enum logic {
    IDLE,
    FADING
  } state_t;

  localparam int LED_PWM_BITS = 8;
  localparam int LED_FADE_DIV = 24000;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period-aligned shadow duty and registered compare.
// RGB_PWM_FADER_ACTIVE_LOW_EN inverts the pad drive for sinking LEDs.
module pwm_channel
  import led_pkg::*;
#(
  parameter int P_BITS = LED_PWM_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [P_BITS-1:0] i_cnt,
  input  logic              i_wrap,
  input  logic [P_BITS-1:0] i_level,
  output logic              o_led
);

`ifdef RGB_PWM_FADER_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic [P_BITS-1:0] duty_q;
  logic              led_q;

  // Duty only changes on the wrap edge, so a period is never cut short.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      duty_q <= '0;
      led_q  <= INV;
    end else begin
      if (i_wrap) duty_q <= i_level;
      led_q <= (i_cnt < duty_q) ^ INV;
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB target handshake, linear per-channel fade and three PWM outputs.
module rgb_pwm_fader
  import led_pkg::*;
#(
  parameter int P_PWM_BITS = LED_PWM_BITS,
  parameter int P_FADE_DIV = LED_FADE_DIV
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [P_PWM_BITS-1:0] i_r,
  input  logic [P_PWM_BITS-1:0] i_g,
  input  logic [P_PWM_BITS-1:0] i_b,
  output logic                  o_busy,
  output logic                  o_led_r,
  output logic                  o_led_g,
  output logic                  o_led_b
);

  localparam int PW = (P_FADE_DIV > 1) ? $clog2(P_FADE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(P_FADE_DIV - 1);

  typedef logic [2:0][P_PWM_BITS-1:0] rgb_t;

  state_t          state_q;
  logic            ready_q;
  logic            busy_q;
  logic [PW-1:0]   ps_q;
  rgb_t            lvl_q;
  rgb_t            lvl_d;
  rgb_t            tgt_q;
  logic [P_PWM_BITS-1:0] cnt_q;
  logic            wrap;
  logic            tick;
  logic            done;
  logic            xfer;
  logic [2:0]      led;

  assign wrap = &cnt_q;
  assign tick = (state_q == FADING) && (ps_q == PS_LAST);
  assign done = (lvl_q == tgt_q);
  assign xfer = i_valid && ready_q;

  always_comb begin
    lvl_d = lvl_q;
    for (int c = 0; c < 3; c++) begin
      if (tick) begin
        if (lvl_q[c] < tgt_q[c])
          lvl_d[c] = lvl_q[c] + 1'b1;
        else if (lvl_q[c] > tgt_q[c])
          lvl_d[c] = lvl_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ps_q    <= '0;
      lvl_q   <= '0;
      tgt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ps_q <= '0;
          if (xfer) begin
            state_q <= FADING;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            tgt_q   <= {i_b, i_g, i_r};
          end else begin
            ready_q <= 1'b1;
          end
        end
        FADING: begin
          // Exit compares the registered levels, hence one extra cycle.
          if (done) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            ps_q    <= '0;
          end else begin
            ps_q  <= tick ? '0 : ps_q + 1'b1;
            lvl_q <= lvl_d;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    pwm_channel #(
      .P_BITS(P_PWM_BITS)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_cnt  (cnt_q),
      .i_wrap (wrap),
      .i_level(lvl_q[c]),
      .o_led  (led[c])
    );
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_led_r = led[0];
  assign o_led_g = led[1];
  assign o_led_b = led[2];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with 4-bit PWM and a divide-by-4 fade.
module tb_rgb_pwm_fader;

  localparam int NB  = 4;
  localparam int DIV = 4;
  localparam int PER = 16;

`ifdef RGB_PWM_FADER_ACTIVE_LOW_EN
  localparam logic OFF = 1'b1;
`else
  localparam logic OFF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [NB-1:0] r, g, b;
  logic          busy;
  logic          led_r, led_g, led_b;

  int checks = 0;
  int errors = 0;

  rgb_pwm_fader #(
    .P_PWM_BITS(NB),
    .P_FADE_DIV(DIV)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid),
    .o_ready(ready),
    .i_r    (r),
    .i_g    (g),
    .i_b    (b),
    .o_busy (busy),
    .o_led_r(led_r),
    .o_led_g(led_g),
    .o_led_b(led_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] r, g, b;
    int  busy;
    int  hr, hg, hb;
    bit  hold;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int hi_exp(input int h);
    return (OFF == 1'b1) ? PER - h : h;
  endfunction

  task automatic idle_leds(input string name, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (led_r !== OFF || led_g !== OFF || led_b !== OFF) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic send(input logic [NB-1:0] cr, input logic [NB-1:0] cg,
                      input logic [NB-1:0] cb);
    int k;
    for (k = 0; k < 200 && ready !== 1'b1; k++) @(negedge clk);
    if (ready !== 1'b1) chk("ready_wait", 0, 1);
    r = cr; g = cg; b = cb;
    valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int nb, nlo, nbad, hr, hg, hb;
    tv[0] = '{4'd4,  4'd0,  4'd0,  17, 4,  0,  0,  1'b0};
    tv[1] = '{4'd1,  4'd15, 4'd15, 61, 1,  15, 15, 1'b0};
    tv[2] = '{4'd1,  4'd15, 4'd15, 1,  1,  15, 15, 1'b0};
    tv[3] = '{4'd0,  4'd7,  4'd15, 33, 0,  7,  15, 1'b1};
    tv[4] = '{4'd10, 4'd7,  4'd3,  49, 10, 7,  3,  1'b1};
    tv[5] = '{4'd0,  4'd0,  4'd0,  41, 0,  0,  0,  1'b0};

    rst = 1'b1; valid = 1'b0; r = '0; g = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", int'(ready), 1);
    chk("rel_busy", int'(busy), 0);
    idle_leds("rel_leds", 64);

    foreach (tv[i]) begin
      send(tv[i].r, tv[i].g, tv[i].b);
      if (tv[i].hold) begin
        r = ~tv[i].r; g = ~tv[i].g; b = ~tv[i].b;
      end else begin
        valid = 1'b0;
      end
      nb = 0; nlo = 0; nbad = 0;
      for (int k = 0; k < 300; k++) begin
        if (busy !== 1'b1) break;
        nb++;
        if (ready !== 1'b1) nlo++;
        else nbad++;
        @(negedge clk);
      end
      valid = 1'b0;
      chk($sformatf("v%0d_busy", i), nb, tv[i].busy);
      chk($sformatf("v%0d_ready_lo", i), nlo, tv[i].busy);
      chk($sformatf("v%0d_ready_in_busy", i), nbad, 0);
      chk($sformatf("v%0d_ready_after", i), int'(ready), 1);
      repeat (40) @(negedge clk);
      hr = 0; hg = 0; hb = 0;
      for (int k = 0; k < PER; k++) begin
        hr += int'(led_r === 1'b1);
        hg += int'(led_g === 1'b1);
        hb += int'(led_b === 1'b1);
        @(negedge clk);
      end
      chk($sformatf("v%0d_duty_r", i), hr, hi_exp(tv[i].hr));
      chk($sformatf("v%0d_duty_g", i), hg, hi_exp(tv[i].hg));
      chk($sformatf("v%0d_duty_b", i), hb, hi_exp(tv[i].hb));
    end

    // Reset while levels sit at 7 on the way to full scale.
    send(4'd15, 4'd15, 4'd15);
    valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_led_r", int'(led_r), int'(OFF));
    chk("mid_rst_led_g", int'(led_g), int'(OFF));
    chk("mid_rst_led_b", int'(led_b), int'(OFF));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", int'(ready), 1);
    idle_leds("mid_rel_leds", 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Downstream LED stage between a pattern source and the RGB pads.
- Accepts an RGB target colour through a valid/ready handshake.
- Ramps each channel's brightness linearly toward its target, one LSB per fade tick.
- Drives the three LED pins with glitch-free PWM. Runs in the 24 MHz PLL clock domain.

Parameters:
- P_PWM_BITS, 8: brightness and PWM counter width. PWM period is 2^P_PWM_BITS cycles.
- P_FADE_DIV, 24000: clock cycles per fade tick (1 ms at 24 MHz). Must be ≥ 2.

Ports:
- i_clk, in, 1: system clock (PLL output).
- i_rst, in, 1: synchronous reset, active-high.
- i_valid, in, 1: colour command valid.
- o_ready, out, 1: fader accepts a command this cycle.
- i_r, in, P_PWM_BITS: target red level.
- i_g, in, P_PWM_BITS: target green level.
- i_b, in, P_PWM_BITS: target blue level.
- o_busy, out, 1: fade in progress.
- o_led_r, out, 1: red PWM output.
- o_led_g, out, 1: green PWM output.
- o_led_b, out, 1: blue PWM output.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high. All state changes occur on the rising edge of i_clk.
- Reset values:
  - current levels, targets, PWM counter, shadow duties, prescaler: 0.
  - state: IDLE.
  - o_busy = 0.
  - o_led_* = 0 (inactive level).
  - o_ready = 0 while i_rst is high, 1 in the first cycle after release.
- Handshake:
  - Transfer occurs when i_valid && o_ready.
  - Targets are captured from i_r/i_g/i_b on that edge.
  - i_valid while o_ready = 0 is ignored. There is no queueing and no error.
  - o_ready = (state == IDLE), registered.
- State machine (IDLE, FADING):
  - IDLE -> FADING on transfer. Prescaler clears to 0 on the same edge.
  - FADING -> IDLE on the edge where all three current levels equal their targets. The equality check is made every cycle.
  - A command equal to the current levels therefore holds o_ready low for exactly one cycle.
  - o_busy = (state == FADING).
- Prescaler:
  - Counts 0..P_FADE_DIV-1 in FADING, then wraps.
  - A fade tick is asserted on the terminal count, so the first step occurs P_FADE_DIV cycles after the transfer.
  - The prescaler is held at 0 in IDLE.
- Fade step, on each tick and independently per channel:
  - level < target: +1.
  - level > target: -1.
  - level == target: hold.
  - No overflow is possible. Fade duration = P_FADE_DIV × max|target − level| cycles, plus 1 cycle for the exit check.
- PWM:
  - One free-running P_PWM_BITS counter shared by all channels. It wraps from 2^N−1 to 0 and runs in every state, including IDLE.
  - Each channel's shadow duty loads from its current level when counter == 2^N−1. New duties take effect only at a period boundary.
  - o_led_x is registered (counter < shadow_x), i.e. 1 cycle latency from the counter.
  - Duty 0: constantly off. Duty 2^N−1: high for 2^N−1 of every 2^N cycles. Full-on is intentionally unreachable.
- Reset mid-fade: all state returns to reset values on that edge. The fade is abandoned, outputs go inactive, and no partial level is retained.
- Simultaneous events: a fade tick and a PWM wrap on the same edge give a shadow load of the pre-step level. The new level appears one period later.

Optional Feature:
- Macro: RGB_PWM_FADER_ACTIVE_LOW_EN.
- Defined:
  - o_led_* are inverted for active-low (sinking) LED pads.
  - Reset/inactive value is 1.
  - Duty 0 drives constant 1.
- Undefined: active-high outputs as described above.
- Handshake, fade and timing are identical in both builds.

Decomposition:
- Shared package led_pkg holds:
  - state enum (IDLE, FADING);
  - default PWM width constant 8;
  - default fade divider constant 24000.
- Sub-module pwm_channel, instantiated 3×:
  - inputs: shared counter, wrap strobe, level;
  - contains the shadow duty register and the registered compare output, including the active-low inversion.
- The fade logic and FSM stay in the top of rgb_pwm_fader.

Test Plan (P_PWM_BITS=4, P_FADE_DIV=4):
1. Reset release, i_valid=0 -> o_ready=1 and o_busy=0 from the first cycle; all o_led_*=0 for 64 cycles.
2. Command r=4, g=0, b=0 -> o_busy high for 4×4+1 cycles; red level steps 1,2,3,4 every 4 cycles. Final red duty: high 4 of every 16 cycles. Green and blue stay 0.
3. From r=4, command r=1, g=15, b=15 -> red decrements to 1 after 12 cycles; fade ends after 15 ticks (61 cycles). Green and blue are high 15/16 of the period.
4. i_valid held high during FADING with different colours -> ignored. Only the first transfer's targets are reached; o_ready stays 0 until done.
5. Command equal to current levels -> o_ready low exactly 1 cycle; no PWM change.
6. i_rst asserted mid-fade at level 7 -> next cycle levels 0, outputs inactive, o_ready 0. Repeat with RGB_PWM_FADER_ACTIVE_LOW_EN defined: outputs 1 at reset, inverted waveform in scenario 2.
